// File: rtl/tia_write_sequencer_if.sv
// Command handshake between the host stimulus and tia_write_sequencer.
// master = host side (frame compiler / harness), slave = sequencer.
interface tia_write_sequencer_if #(
  parameter int DLY_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [5:0]       cmd_addr;
  logic [7:0]       cmd_data;
  logic [DLY_W-1:0] cmd_delay;

  modport master (
    output cmd_valid, cmd_addr, cmd_data, cmd_delay,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, cmd_delay,
    output cmd_ready
  );
endinterface

// File: rtl/tia_write_sequencer.sv
// tia_write_sequencer: buffers timed TIA register writes and replays them as phi_theta-aligned bus cycles.
// Define TIA_WRITE_SEQUENCER_STATS_EN to add the stat_writes / stat_stalls saturating counters.
module tia_write_sequencer #(
  parameter int DEPTH = 4,
  parameter int DLY_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 phi_theta,
  input  logic                 rdy,
  tia_write_sequencer_if.slave cmd,
  output logic [5:0]           a,
  output logic [7:0]           d,
  output logic                 rw,
  output logic                 phi2,
  output logic                 busy
`ifdef TIA_WRITE_SEQUENCER_STATS_EN
  ,
  output logic [15:0]          stat_writes,
  output logic [15:0]          stat_stalls
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef struct packed {
    logic [5:0]       addr;
    logic [7:0]       data;
    logic [DLY_W-1:0] delay;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic             phi_theta_q;
  logic             tick;
  logic             synced;
  logic [1:0]       phase;
  logic [1:0]       state;
  logic [DLY_W-1:0] dcnt;
  logic [5:0]       w_addr;
  logic [7:0]       w_data;

  assign tick          = phi_theta & ~phi_theta_q;
  assign fifo_empty    = (count == '0);
  assign cmd.cmd_ready = (count != CW'(DEPTH));
  assign push          = cmd.cmd_valid & cmd.cmd_ready;
  // The head is consumed from IDLE or at the end of a WRITE, never from WAIT or a stalled tick.
  assign pop           = tick & rdy & (state != ST_WAIT) & ~fifo_empty;
  assign head          = mem[rd_ptr];
  assign phi2          = synced & (phase == 2'd1);
  assign busy          = ~fifo_empty | (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; entries are only read after being written under the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: cmd.cmd_addr, data: cmd.cmd_data, delay: cmd.cmd_delay};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phi_theta_q <= 1'b0;
      synced      <= 1'b0;
      phase       <= 2'd0;
      state       <= ST_IDLE;
      dcnt        <= '0;
      w_addr      <= '0;
      w_data      <= '0;
      a           <= '0;
      d           <= '0;
      rw          <= 1'b1;
    end else begin
      phi_theta_q <= phi_theta;
      // Phase only advances once a tick has been seen, so a stopped phi_theta keeps phi2 low.
      if (tick) begin
        phase  <= 2'd0;
        synced <= 1'b1;
      end else if (synced && phase != 2'd2) begin
        phase  <= phase + 2'd1;
      end

      if (tick) begin
        rw <= 1'b1;
        if (rdy) begin
          if (state == ST_WAIT) begin
            dcnt <= dcnt - DLY_W'(1);
            if (dcnt == DLY_W'(1)) begin
              state <= ST_WRITE;
              a     <= w_addr;
              d     <= w_data;
              rw    <= 1'b0;
            end
          end else if (pop) begin
            w_addr <= head.addr;
            w_data <= head.data;
            dcnt   <= head.delay;
            if (head.delay == '0) begin
              state <= ST_WRITE;
              a     <= head.addr;
              d     <= head.data;
              rw    <= 1'b0;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      end
    end
  end

`ifdef TIA_WRITE_SEQUENCER_STATS_EN
  // A tick with rw low closes the write cycle that was on the bus, stalled or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_writes <= '0;
      stat_stalls <= '0;
    end else if (tick) begin
      if (!rw && stat_writes != 16'hFFFF)  stat_writes <= stat_writes + 16'd1;
      if (!rdy && stat_stalls != 16'hFFFF) stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_tia_write_sequencer.sv
// Self-checking bench for tia_write_sequencer: vector table, hand-written corner sequences
// and a write scoreboard fed at command acceptance and drained on bus write cycles.
module tb_tia_write_sequencer;
  localparam int DEPTH = 4;
  localparam int DLY_W = 8;

  typedef struct {
    logic [5:0]       addr;
    logic [7:0]       data;
    logic [DLY_W-1:0] delay;
    int               exp_idle;
  } vec_t;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       phi_theta = 1'b0;
  logic       rdy = 1'b1;
  logic [5:0] a;
  logic [7:0] d;
  logic       rw;
  logic       phi2;
  logic       busy;
`ifdef TIA_WRITE_SEQUENCER_STATS_EN
  logic [15:0] stat_writes;
  logic [15:0] stat_stalls;
`endif

  int  n_checks = 0;
  int  n_pass   = 0;
  wr_t sb[$];
  vec_t vecs[6];

  tia_write_sequencer_if #(.DLY_W(DLY_W)) cmd_if ();

  tia_write_sequencer #(.DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .phi_theta (phi_theta),
    .rdy       (rdy),
    .cmd       (cmd_if),
    .a         (a),
    .d         (d),
    .rw        (rw),
    .phi2      (phi2),
    .busy      (busy)
`ifdef TIA_WRITE_SEQUENCER_STATS_EN
    ,
    .stat_writes (stat_writes),
    .stat_stalls (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Divide-by-three CPU clock: phi_theta is high for one clk in three while enabled.
  bit phi_en = 1'b1;
  int div = 2;
  always @(negedge clk) begin
    if (phi_en) begin
      div       = (div == 2) ? 0 : div + 1;
      phi_theta = (div == 0);
    end else begin
      div       = 2;
      phi_theta = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference timing: tick and phase as seen at each posedge, checked at the following negedge.
  bit         tb_tick, phi_prev, synced, rst_edge, mon_en;
  int         tb_phase;
  logic [5:0] prev_a;
  logic [7:0] prev_d;
  logic       prev_rw;

  // NOTE: DUT outputs are sampled on the falling edge, half a clock away from the active edge.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        tb_tick = 1'b0; phi_prev = 1'b0; tb_phase = 0; synced = 1'b0; rst_edge = 1'b1;
      end else begin
        tb_tick  = phi_theta & ~phi_prev;
        phi_prev = phi_theta;
        rst_edge = 1'b0;
        if (tb_tick) begin
          tb_phase = 0; synced = 1'b1;
        end else if (synced && tb_phase != 2) begin
          tb_phase++;
        end
      end
      @(negedge clk);
      if (mon_en) begin
        check("phi2", {31'd0, phi2}, {31'd0, (synced && tb_phase == 1)});
        if (tb_tick && rw === 1'b0) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: a=0x%0h d=0x%0h with nothing queued (t=%0t)", a, d, $time);
          end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", {26'd0, a}, {26'd0, e.addr});
            check("wr_data", {24'd0, d}, {24'd0, e.data});
          end
        end else if (!tb_tick && !rst_edge) begin
          check("bus_hold", {17'd0, a, d, rw}, {17'd0, prev_a, prev_d, prev_rw});
        end
      end
      prev_a = a; prev_d = d; prev_rw = rw;
    end
  end

  task automatic next_tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tb_tick) return;
    end
    n_checks++;
    $display("FAIL tick_timeout: no tick within 8 clks, required one (t=%0t)", $time);
  endtask

  // Called at a negedge; offers the command until accepted and returns at the negedge after.
  task automatic push_cmd(input logic [5:0] ad, input logic [7:0] da, input logic [DLY_W-1:0] dl);
    wr_t w;
    cmd_if.cmd_addr  = ad;
    cmd_if.cmd_data  = da;
    cmd_if.cmd_delay = dl;
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_if.cmd_ready === 1'b1) begin
        w.addr = ad; w.data = da;
        sb.push_back(w);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
    n_checks++;
    $display("FAIL push_timeout: cmd_ready stayed 0 for 20 clks, required 1");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_a",     {26'd0, a}, 32'd0);
    check("rst_d",     {24'd0, d}, 32'd0);
    check("rst_rw",    {31'd0, rw}, 32'd1);
    check("rst_phi2",  {31'd0, phi2}, 32'd0);
    check("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idle;
    bit  found;
    wr_t w;

    vecs[0] = '{addr: 6'h3F, data: 8'hFF, delay: 8'd0,   exp_idle: 0};
    vecs[1] = '{addr: 6'h00, data: 8'h00, delay: 8'd1,   exp_idle: 1};
    vecs[2] = '{addr: 6'h2A, data: 8'h55, delay: 8'd3,   exp_idle: 3};
    vecs[3] = '{addr: 6'h15, data: 8'hAA, delay: 8'd2,   exp_idle: 2};
    vecs[4] = '{addr: 6'h01, data: 8'h80, delay: 8'd7,   exp_idle: 7};
    vecs[5] = '{addr: 6'h2C, data: 8'hC3, delay: 8'd255, exp_idle: 255};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_addr  = '0;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_delay = '0;

    // Single write: bus timing across one CPU cycle.
    do_reset();
    mon_en = 1'b1;
    next_tick();
    push_cmd(6'h09, 8'h1E, 8'd0);
    check("t1_busy_queued", {31'd0, busy}, 32'd1);
    next_tick();
    check("t1_rw_p0",   {31'd0, rw}, 32'd0);
    check("t1_a_p0",    {26'd0, a}, 32'h09);
    check("t1_d_p0",    {24'd0, d}, 32'h1E);
    check("t1_phi2_p0", {31'd0, phi2}, 32'd0);
    @(negedge clk);
    check("t1_phi2_p1", {31'd0, phi2}, 32'd1);
    check("t1_rw_p1",   {31'd0, rw}, 32'd0);
    @(negedge clk);
    check("t1_phi2_p2", {31'd0, phi2}, 32'd0);
    check("t1_rw_p2",   {31'd0, rw}, 32'd0);
    check("t1_d_p2",    {24'd0, d}, 32'h1E);
    next_tick();
    check("t1_rw_after",   {31'd0, rw}, 32'd1);
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    check("t1_a_held",     {26'd0, a}, 32'h09);

    // Delay table: idle CPU cycles before each write, including the widest delay.
    foreach (vecs[i]) begin
      next_tick();
      push_cmd(vecs[i].addr, vecs[i].data, vecs[i].delay);
      idle  = 0;
      found = 1'b0;
      for (int t = 0; t < 300 && !found; t++) begin
        next_tick();
        if (rw === 1'b0) found = 1'b1;
        else idle++;
      end
      check($sformatf("vec%0d_found", i), {31'd0, found}, 32'd1);
      check($sformatf("vec%0d_idle", i), idle, vecs[i].exp_idle);
      check($sformatf("vec%0d_busy_wr", i), {31'd0, busy}, 32'd1);
      next_tick();
      check($sformatf("vec%0d_rw_done", i), {31'd0, rw}, 32'd1);
      check($sformatf("vec%0d_busy_done", i), {31'd0, busy}, 32'd0);
    end

    // Fill the FIFO with phi_theta stopped, then hold a 5th command through the first pop.
    next_tick();
    phi_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < DEPTH; k++) push_cmd(6'h10 + 6'(k), 8'hA0 + 8'(k), 8'd0);
    check("full_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    check("full_busy",  {31'd0, busy}, 32'd1);
    check("stopped_rw", {31'd0, rw}, 32'd1);
    cmd_if.cmd_addr  = 6'h14;
    cmd_if.cmd_data  = 8'hA4;
    cmd_if.cmd_delay = 8'd0;
    cmd_if.cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_hold_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    end
    phi_en = 1'b1;
    next_tick();
    check("pop_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("pop_rw",    {31'd0, rw}, 32'd0);
    w.addr = 6'h14; w.data = 8'hA4;
    sb.push_back(w);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    check("refill_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      next_tick();
      check($sformatf("b2b_rw%0d", k), {31'd0, rw}, 32'd0);
    end
    next_tick();
    check("b2b_rw_end",   {31'd0, rw}, 32'd1);
    check("b2b_busy_end", {31'd0, busy}, 32'd0);

    // WSYNC halt: five stalled ticks defer the queued write.
    do_reset();
    next_tick();
    push_cmd(6'h02, 8'h00, 8'd0);
    next_tick();
    check("wsync_rw", {31'd0, rw}, 32'd0);
    check("wsync_a",  {26'd0, a}, 32'h02);
    push_cmd(6'h06, 8'h33, 8'd0);
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      next_tick();
      check($sformatf("stall_rw%0d", k), {31'd0, rw}, 32'd1);
      check($sformatf("stall_busy%0d", k), {31'd0, busy}, 32'd1);
    end
    rdy = 1'b1;
    next_tick();
    check("resume_rw", {31'd0, rw}, 32'd0);
    check("resume_a",  {26'd0, a}, 32'h06);
    check("resume_d",  {24'd0, d}, 32'h33);
`ifdef TIA_WRITE_SEQUENCER_STATS_EN
    check("stat_stalls", {16'd0, stat_stalls}, 32'd5);
`endif
    next_tick();
    check("resume_rw_end", {31'd0, rw}, 32'd1);
`ifdef TIA_WRITE_SEQUENCER_STATS_EN
    check("stat_writes", {16'd0, stat_writes}, 32'd2);
`endif

    // Reset asserted in phase 1 of a write, with another command still queued.
    next_tick();
    push_cmd(6'h2A, 8'h5A, 8'd0);
    push_cmd(6'h2B, 8'h5B, 8'd0);
    next_tick();
    check("mid_rw", {31'd0, rw}, 32'd0);
    check("mid_a",  {26'd0, a}, 32'h2A);
    @(negedge clk);
    check("mid_phi2", {31'd0, phi2}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rw",    {31'd0, rw}, 32'd1);
    check("midrst_phi2",  {31'd0, phi2}, 32'd0);
    check("midrst_a",     {26'd0, a}, 32'd0);
    check("midrst_d",     {24'd0, d}, 32'd0);
    check("midrst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    reset = 1'b0;
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      next_tick();
      check($sformatf("postrst_rw%0d", k), {31'd0, rw}, 32'd1);
      check($sformatf("postrst_busy%0d", k), {31'd0, busy}, 32'd0);
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
